// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
// Shared types and sizing helpers for the iterative square-root unit.
//   state_t      : controller states (IDLE / BUSY / DONE)
//   calc_iter    : BUSY cycles per operation for a given width and bits/cycle
//   calc_cnt_w   : iteration counter width (never below one bit)
//   calc_root_w  : root width (WIDTH/2)
//   calc_rem_w   : remainder width (WIDTH/2+1, enough to hold 2*root)
// ---------------------------------------------------------------------------
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_iter(input int width, input int bits_per_cycle);
    return width / (2 * bits_per_cycle);
  endfunction

  function automatic int calc_cnt_w(input int iter);
    int w;
    w = $clog2(iter);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_root_w(input int width);
    return width / 2;
  endfunction

  function automatic int calc_rem_w(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/square_root_stage.sv
// ---------------------------------------------------------------------------
// square_root_stage
// One combinational conditional-subtract step of the digit-by-digit square
// root. Brings the next two radicand bits into the partial remainder, tries
// to subtract (q<<2)|1, and reports whether the subtraction succeeded.
// Ports:
//   r_in   : partial remainder before this step (ROOT_W+2 bits)
//   q_in   : partial root before this step (ROOT_W bits)
//   pair   : next two radicand bits, most significant first
//   r_out  : partial remainder after this step
//   q_bit  : resolved root bit (1 when the trial subtraction fit)
// ---------------------------------------------------------------------------
module square_root_stage #(
  parameter int ROOT_W = 8
) (
  input  logic [ROOT_W+1:0] r_in,
  input  logic [ROOT_W-1:0] q_in,
  input  logic [1:0]        pair,
  output logic [ROOT_W+1:0] r_out,
  output logic              q_bit
);

  logic [ROOT_W+1:0] r_shifted;
  logic [ROOT_W+1:0] trial;
  logic              fits;

  // The remainder never exceeds 2*q, so shifting it left by two inside
  // ROOT_W+2 bits cannot lose significant bits.
  assign r_shifted = (r_in << 2) | {{ROOT_W{1'b0}}, pair};
  assign trial     = {q_in, 2'b01};
  assign fits      = (r_shifted >= trial);

  assign r_out = fits ? (r_shifted - trial) : r_shifted;
  assign q_bit = fits;

endmodule

// File: rtl/sqrt_iterative_unit.sv
// ---------------------------------------------------------------------------
// sqrt_iterative_unit
// Multi-cycle unsigned integer square root with valid/ready on both sides.
// Produces floor(sqrt(radicand)) and radicand - root^2, resolving
// BITS_PER_CYCLE root bits per clock through a chain of square_root_stage.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : radicand presented
//   in_ready   : unit accepts a radicand this cycle
//   radicand   : WIDTH-bit unsigned operand, sampled on accept
//   out_valid  : root/remainder valid
//   out_ready  : consumer takes the result this cycle
//   root       : WIDTH/2-bit root
//   remainder  : WIDTH/2+1-bit remainder (always <= 2*root)
// ---------------------------------------------------------------------------
module sqrt_iterative_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         radicand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH/2-1:0]       root,
  output logic [WIDTH/2:0]         remainder
);

  localparam int ITER   = calc_iter(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W  = calc_cnt_w(ITER);
  localparam int ROOT_W = calc_root_w(WIDTH);
  localparam int REM_W  = calc_rem_w(WIDTH);
  localparam int PART_W = ROOT_W + 2;

  if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("sqrt_iterative_unit: WIDTH must be even and >= 4");
  end
  if ((BITS_PER_CYCLE < 1) || ((WIDTH / 2) % BITS_PER_CYCLE != 0)) begin : g_bad_bpc
    $error("sqrt_iterative_unit: BITS_PER_CYCLE must divide WIDTH/2");
  end

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [PART_W-1:0] r_reg;
  logic [ROOT_W-1:0] q_reg;
  logic [CNT_W-1:0]  cnt;

  logic [PART_W-1:0]         r_chain [BITS_PER_CYCLE+1];
  logic [ROOT_W-1:0]         q_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [WIDTH-1:0]          shift_next;
  logic                      accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign r_chain[0] = r_reg;
  assign q_chain[0] = q_reg;

  // Each chained stage consumes the next radicand bit pair, most significant
  // pair first, so stage k reads the pair 2k bits below the top.
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_stage
    square_root_stage #(
      .ROOT_W(ROOT_W)
    ) u_stage (
      .r_in  (r_chain[k]),
      .q_in  (q_chain[k]),
      .pair  (shift_reg[WIDTH-1-2*k -: 2]),
      .r_out (r_chain[k+1]),
      .q_bit (q_bits[k])
    );
    assign q_chain[k+1] = {q_chain[k][ROOT_W-2:0], q_bits[k]};
  end

  assign shift_next = shift_reg << (2 * BITS_PER_CYCLE);

  // Controller, iteration datapath and result registers. A DONE result is
  // frozen until the consumer takes it; a new radicand may be accepted on the
  // same edge the result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      root      <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= radicand;
            r_reg     <= '0;
            q_reg     <= '0;
            cnt       <= CNT_W'(ITER - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          shift_reg <= shift_next;
          r_reg     <= r_chain[BITS_PER_CYCLE];
          q_reg     <= q_chain[BITS_PER_CYCLE];
          if (cnt == '0) begin
            root      <= q_chain[BITS_PER_CYCLE];
            remainder <= r_chain[BITS_PER_CYCLE][REM_W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              shift_reg <= radicand;
              r_reg     <= '0;
              q_reg     <= '0;
              cnt       <= CNT_W'(ITER - 1);
              state     <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iterative_unit.sv
// Directed bench for sqrt_iterative_unit: a WIDTH=16 unit driven from a
// vector table plus backpressure / handoff / mid-operation reset sequences,
// a WIDTH=32 two-bits-per-cycle unit on its boundary value, and a WIDTH=8
// unit swept over every operand with random consumer stalls.
module tb_sqrt_iterative_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // WIDTH=16, BITS_PER_CYCLE=1
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] radicand;
  logic [7:0]  root;
  logic [8:0]  remainder;

  // WIDTH=32, BITS_PER_CYCLE=2
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] radicand32;
  logic [15:0] root32;
  logic [16:0] remainder32;

  // WIDTH=8, BITS_PER_CYCLE=1
  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] radicand8;
  logic [3:0] root8;
  logic [4:0] remainder8;

  int errors = 0;
  int checks = 0;

  sqrt_iterative_unit #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .radicand(radicand),
    .out_valid(out_valid), .out_ready(out_ready),
    .root(root), .remainder(remainder)
  );

  sqrt_iterative_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32), .radicand(radicand32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .root(root32), .remainder(remainder32)
  );

  sqrt_iterative_unit #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .radicand(radicand8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .root(root8), .remainder(remainder8)
  );

  typedef struct {
    logic [15:0] x;
    logic [7:0]  exp_root;
    logic [8:0]  exp_rem;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Presents x on the 16-bit unit and returns once it has been accepted.
  task automatic startOp(input logic [15:0] x);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    radicand = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    radicand = 16'($urandom);
  endtask

  // Counts rising edges from the accept edge until out_valid is seen.
  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [15:0] x, output int lat);
    startOp(x);
    waitResult(lat);
  endtask

  initial begin
    int lat;
    int n;
    int ref_root;

    rst = 1'b1;
    in_valid = 1'b0;  radicand = '0;   out_ready = 1'b1;
    in_valid32 = 1'b0; radicand32 = '0; out_ready32 = 1'b1;
    in_valid8 = 1'b0; radicand8 = '0;  out_ready8 = 1'b0;

    vecs[0] = '{16'd144,   8'd12,  9'd0};
    vecs[1] = '{16'd145,   8'd12,  9'd1};
    vecs[2] = '{16'd0,     8'd0,   9'd0};
    vecs[3] = '{16'd65535, 8'd255, 9'd510};
    vecs[4] = '{16'd2,     8'd1,   9'd1};

    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_root", root, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].x, lat);
      checkOutput($sformatf("latency_%0d", vecs[i].x), lat, 8);
      checkOutput($sformatf("root_%0d", vecs[i].x), root, vecs[i].exp_root);
      checkOutput($sformatf("rem_%0d", vecs[i].x), remainder, vecs[i].exp_rem);
    end
    @(posedge clk);
    #1;
    checkOutput("idle_after_take_out_valid", out_valid, 0);
    checkOutput("idle_after_take_root_kept", root, 1);

    // Backpressure: result for 1000 must stay frozen while out_ready=0.
    out_ready = 1'b0;
    applyStimulus(16'd1000, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_root", root, 31);
      checkOutput("stall_rem", remainder, 39);
      checkOutput("stall_in_ready", in_ready, 0);
    end

    // Same-edge handoff of the result and acceptance of 81.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    radicand = 16'd81;
    #1;
    checkOutput("handoff_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    radicand = 16'hBEEF;
    checkOutput("handoff_out_valid_drop", out_valid, 0);
    checkOutput("handoff_busy_in_ready", in_ready, 0);
    waitResult(lat);
    checkOutput("handoff_latency", lat, 8);
    checkOutput("root_81", root, 9);
    checkOutput("rem_81", remainder, 0);

    // Reset three cycles into an operation.
    startOp(16'd50000);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_root", root, 0);
    checkOutput("midreset_rem", remainder, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'd50000, lat);
    checkOutput("latency_50000", lat, 8);
    checkOutput("root_50000", root, 223);
    checkOutput("rem_50000", remainder, 271);

    // Two bits per cycle on a 32-bit operand.
    @(negedge clk);
    in_valid32 = 1'b1;
    radicand32 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid32 && lat < 40);
    checkOutput("w32_latency", lat, 8);
    checkOutput("w32_root", root32, 65535);
    checkOutput("w32_rem", remainder32, 131070);

    // Full WIDTH=8 sweep with random consumer stalls.
    for (int x = 0; x < 256; x++) begin
      ref_root = 0;
      while ((ref_root + 1) * (ref_root + 1) <= x) ref_root++;
      @(negedge clk);
      n = 0;
      while (!in_ready8 && n < 20) begin
        @(negedge clk);
        n++;
      end
      in_valid8 = 1'b1;
      radicand8 = 8'(x);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      radicand8 = 8'($urandom);
      n = 0;
      while (!out_valid8 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput($sformatf("w8_%0d", x),
                  {out_valid8, root8, remainder8},
                  {1'b1, 4'(ref_root), 5'(x - ref_root * ref_root)});
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk);
      #1;
      out_ready8 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_iterative_unit.md
Name: sqrt_iterative_unit

Overview:
- Multi-cycle integer square root built on the existing combinational conditional-subtract square-root stage.
- Computes floor(sqrt(radicand)) and remainder = radicand - root^2 for an unsigned WIDTH-bit operand, BITS_PER_CYCLE root bits per clock.
- Valid/ready on both sides; sits in the Special Unit datapath between the operand register file and the result writeback.

Parameters:
WIDTH, 16, radicand width in bits; even, >= 4
BITS_PER_CYCLE, 1, root bits resolved per clock (chained stages per cycle); must divide WIDTH/2
ITER (localparam), WIDTH/(2*BITS_PER_CYCLE), BUSY cycles per operation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  radicand presented
in_ready  out  1  unit can accept a radicand this cycle
radicand  in  WIDTH  unsigned operand, sampled only on accept
out_valid  out  1  root/remainder valid
out_ready  in  1  consumer takes result this cycle
root  out  WIDTH/2  floor(sqrt(radicand))
remainder  out  WIDTH/2+1  radicand - root^2, always <= 2*root

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; out_valid=0; root=0; remainder=0; internal shift/partial regs=0; in-flight operation discarded.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; no dependency on in_valid.
- Accept = in_valid & in_ready at a rising edge:
  - load radicand into shift register; clear partial remainder r and partial root q; iteration counter = ITER-1; go BUSY.
- BUSY, per cycle, BITS_PER_CYCLE chained stage steps, each:
  - r = (r<<2) | top two radicand bits; shift radicand left 2.
  - trial = (q<<2) | 1, WIDTH/2+2 bits.
  - If r >= trial: r = r - trial, q = (q<<1)|1. Else r unchanged, q = q<<1.
  - r is held in WIDTH/2+2 bits internally; upper bit is provably 0 at completion.
- BUSY exit:
  - counter==0 -> DONE, root=q, remainder=r[WIDTH/2:0], out_valid=1.
  - Otherwise decrement the counter.
- Latency: out_valid rises exactly ITER cycles after the accept edge (WIDTH=16, BITS_PER_CYCLE=1: 8 cycles; BITS_PER_CYCLE=2: 4).
- DONE:
  - root/remainder/out_valid held stable while out_ready=0 (no-drop, no-change rule).
  - out_ready=1 and in_valid=0 -> IDLE, out_valid=0; root/remainder keep last value.
  - out_ready=1 and in_valid=1 -> handoff and new accept on the same edge, go BUSY, out_valid=0 next cycle. Throughput is one op per ITER+1 cycles.
- radicand/in_valid changes during BUSY are ignored; in_ready=0 there.
- out_ready while out_valid=0 has no effect.
- Arithmetic is unsigned throughout; no overflow case exists.
- Boundary values:
  - radicand=0 -> root=0, remainder=0.
  - radicand=2^WIDTH-1 -> root=2^(WIDTH/2)-1, remainder=2^(WIDTH/2+1)-2.

Decomposition:
- Shared package sqrt_pkg:
  - state enum (IDLE/BUSY/DONE);
  - functions computing ITER and counter width ($clog2(ITER), min 1);
  - width localparams ROOT_W=WIDTH/2, REM_W=WIDTH/2+1.
- One natural sub-module: square_root_stage, the combinational conditional-subtract stage.
  - Instantiated BITS_PER_CYCLE times in a generate chain.
  - Outputs: q bit and next partial remainder.
- FSM, counter, shift registers and handshake stay in the top module.

Test Plan:
- WIDTH=16, BITS_PER_CYCLE=1, out_ready=1:
  - radicand=144 -> root=12, remainder=0; out_valid exactly 8 cycles after accept.
  - radicand=145 -> root=12, remainder=1.
- Boundaries: radicand=0 -> 0/0; radicand=65535 -> root=255, remainder=510; radicand=2 -> root=1, remainder=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid on radicand=1000 -> root=31, remainder=39 held stable, in_ready=0. Then out_ready=1 with in_valid=1 and radicand=81 -> same-edge handoff, then root=9, remainder=0.
- Reset mid-op: assert rst 3 cycles into BUSY on radicand=50000 -> outputs 0 immediately, state IDLE, in_ready=1. Next radicand=50000 -> root=223, remainder=271.
- BITS_PER_CYCLE=2 and WIDTH=32: radicand=4294967295 -> root=65535, remainder=131070, latency 8.
- Exhaustive WIDTH=8 sweep 0..255 checked against a reference model: root^2 <= x < (root+1)^2 and remainder = x - root^2, with randomised out_ready stalls.
